// File: rtl/conv_pkg.sv
// Shared FSM encoding and size derivations for the conv2d systolic engine.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int out_n(input int img_n, input int k);
        return img_n - k + 1;
    endfunction

    function automatic int acc_w(input int data_w, input int k);
        return 2 * data_w + clog2_min1(k * k);
    endfunction

endpackage

// File: rtl/conv_pe.sv
// Multiply-accumulate PE: acc += a*b when enabled, one cycle per tap; clear wins over enable.
// No backpressure: the caller gates enable.
module conv_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q + ACC_W'(a) * ACC_W'(b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv2d_systolic_engine.sv
// Row-at-a-time 2D convolution: OUT_N PEs, K*K MAC cycles per row, then one beat per column
// held under out_valid/out_ready backpressure. Define CONV_SAT_EN to saturate instead of wrap.
module conv2d_systolic_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_N  = 4,
    parameter int K      = 3,
    localparam int OUT_N = out_n(IMG_N, K),
    localparam int ACC_W = acc_w(DATA_W, K),
    localparam int AW    = clog2_min1(IMG_N * IMG_N),
    localparam int CW    = clog2_min1(OUT_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              done
);

    localparam int KW = clog2_min1(K);
    localparam int FW = clog2_min1(K * K);

    state_e            state_q, state_d;
    logic [KW-1:0]     ki_q, ki_d, kj_q, kj_d;
    logic [CW-1:0]     row_q, row_d, col_q, col_d;
    logic              done_q;
    logic [DATA_W-1:0] img_q [IMG_N*IMG_N];
    logic [DATA_W-1:0] flt_q [K*K];
    logic [DATA_W-1:0] pe_a  [OUT_N];
    logic [DATA_W-1:0] pe_b;
    logic [ACC_W-1:0]  pe_acc [OUT_N];
    logic [ACC_W-1:0]  sel_acc;
    logic              acc_clr, mac_en, beat_acc;

    always_comb begin
        state_d  = state_q;
        ki_d     = ki_q;
        kj_d     = kj_q;
        row_d    = row_q;
        col_d    = col_q;
        beat_acc = (state_q == ST_EMIT) && out_ready;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_MAC;
                    ki_d    = '0;
                    kj_d    = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_MAC: begin
                if (kj_q == KW'(K - 1)) begin
                    kj_d = '0;
                    if (ki_q == KW'(K - 1)) begin
                        ki_d    = '0;
                        state_d = ST_EMIT;
                    end else begin
                        ki_d = ki_q + 1'b1;
                    end
                end else begin
                    kj_d = kj_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (beat_acc) begin
                    if (col_q == CW'(OUT_N - 1)) begin
                        col_d = '0;
                        if (row_q == CW'(OUT_N - 1)) begin
                            state_d = ST_FIN;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = ST_MAC;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                row_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        acc_clr = (state_d == ST_MAC) && (state_q != ST_MAC);
        mac_en  = (state_q == ST_MAC);
    end

    // Tap (ki,kj) of the current row: PE j sees img[row+ki][j+kj], all PEs share f[ki][kj].
    always_comb begin
        pe_b = flt_q[FW'(int'(ki_q) * K + int'(kj_q))];
        for (int j = 0; j < OUT_N; j++) begin
            pe_a[j] = img_q[AW'((int'(row_q) + int'(ki_q)) * IMG_N + j + int'(kj_q))];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ki_q    <= '0;
            kj_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ki_q    <= ki_d;
            kj_q    <= kj_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= (state_q == ST_FIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMG_N * IMG_N; i++) img_q[i] <= '0;
            for (int i = 0; i < K * K; i++) flt_q[i] <= '0;
        end else if (wr_en && (state_q == ST_IDLE)) begin
            if (!wr_sel) begin
                if (int'(wr_addr) < IMG_N * IMG_N) img_q[wr_addr] <= wr_data;
            end else if (int'(wr_addr) < K * K) begin
                flt_q[FW'(wr_addr)] <= wr_data;
            end
        end
    end

    for (genvar j = 0; j < OUT_N; j++) begin : g_pe
        conv_pe #(
            .DATA_W(DATA_W),
            .ACC_W (ACC_W)
        ) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clear (acc_clr),
            .enable(mac_en),
            .a     (pe_a[j]),
            .b     (pe_b),
            .acc   (pe_acc[j])
        );
    end

    assign sel_acc = pe_acc[col_q];

`ifdef CONV_SAT_EN
    assign out_data = (sel_acc > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : DATA_W'(sel_acc);
`else
    assign out_data = DATA_W'(sel_acc);
`endif

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_EMIT);
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign done      = done_q;

endmodule
